// File: rtl/ifetch_pkg.sv
// Shared widths, constants and the fetch-buffer entry type for the instruction-fetch front end.
package ifetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Registered DEPTH-entry fetch buffer (fetch_fifo); the head is always a stored entry, never fall-through.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap by truncation because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC register, fetch/redirect control and a registered fetch buffer.
// Optional perf counters (fetch_cnt, stall_cnt) are built when IFETCH_PERF_EN is defined.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2,
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  Address,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [CNT_W-1:0]   buf_count
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    // Handshake: a head entry transfers to decode on any rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head is held stable until it transfers.
    logic [ADDR_W-1:0] pc;
    logic              pop;
    logic              push;
    logic              buf_full;
    logic              buf_empty;
    fetch_entry_t      head;
    fetch_entry_t      entry_in;

    assign Address   = pc;
    assign out_valid = ~buf_empty;
    assign pop       = out_valid & out_ready;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign push      = ~redirect_valid & (~buf_full | pop);
    assign entry_in  = '{instr: instruction, pc: pc};
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + ADDR_W'(PC_STEP);
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (entry_in),
        .dout  (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) fetch_cnt <= fetch_cnt + 1'b1;
            if (!push && !redirect_valid) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
